// File: rtl/ex_pipe_reg.sv
// ex_pipe_reg: EX->MEM pipeline register with a valid/ready handshake, a
// one-entry skid buffer, exception folding, a kill window and a saturating
// count of exceptional beats delivered downstream.
module ex_pipe_reg #(
  parameter int unsigned ADDR_W   = 30,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned EXP_W    = 3,
  parameter int unsigned MEMOP_W  = 2,
  parameter int unsigned CTRLOP_W = 2,
  parameter int unsigned EXP_NONE = 0,
  parameter int unsigned EXP_INT  = 1,
  parameter int unsigned EXP_OVF  = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                int_detect,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_pc,
  input  logic                in_en,
  input  logic                in_br_flag,
  input  logic [EXP_W-1:0]    in_exp_code,
  input  logic [MEMOP_W-1:0]  in_mem_op,
  input  logic [DATA_W-1:0]   in_mem_wr_data,
  input  logic [CTRLOP_W-1:0] in_ctrl_op,
  input  logic [REG_AW-1:0]   in_dst_addr,
  input  logic                in_gpr_we_,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                alu_overflow,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_pc,
  output logic                out_en,
  output logic                out_br_flag,
  output logic [EXP_W-1:0]    out_exp_code,
  output logic [MEMOP_W-1:0]  out_mem_op,
  output logic [DATA_W-1:0]   out_mem_wr_data,
  output logic [CTRLOP_W-1:0] out_ctrl_op,
  output logic [REG_AW-1:0]   out_dst_addr,
  output logic                out_gpr_we_,
  output logic [DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]    exc_cnt
);

  localparam logic [EXP_W-1:0] EXP_NONE_C = EXP_W'(EXP_NONE);
  localparam logic [EXP_W-1:0] EXP_INT_C  = EXP_W'(EXP_INT);
  localparam logic [EXP_W-1:0] EXP_OVF_C  = EXP_W'(EXP_OVF);

  typedef struct packed {
    logic [ADDR_W-1:0]   pc;
    logic                en;
    logic                br_flag;
    logic [EXP_W-1:0]    exp_code;
    logic [MEMOP_W-1:0]  mem_op;
    logic [DATA_W-1:0]   mem_wr_data;
    logic [CTRLOP_W-1:0] ctrl_op;
    logic [REG_AW-1:0]   dst_addr;
    logic                gpr_we_;
    logic [DATA_W-1:0]   data;
  } beat_t;

  localparam beat_t BEAT_RST = '{
    pc:          '0,
    en:          1'b0,
    br_flag:     1'b0,
    exp_code:    EXP_NONE_C,
    mem_op:      '0,
    mem_wr_data: '0,
    ctrl_op:     '0,
    dst_addr:    '0,
    gpr_we_:     1'b1,
    data:        '0
  };

  beat_t            main_q;
  beat_t            skid_q;
  logic             out_valid_q;
  logic             skid_valid_q;
  logic             in_ready_q;
  logic             int_pend_q;
  logic             kill_q;
  logic [CNT_W-1:0] exc_cnt_q;

  beat_t in_beat_c;
  beat_t san_beat_c;
  logic  accept_c;
  logic  xfer_c;
  logic  load_main_c;
  logic  skid_valid_d_c;

  // Handshake qualifiers; flush pre-empts both accept and transfer.
  always_comb begin
    accept_c    = in_valid & in_ready_q & ~flush;
    xfer_c      = out_valid_q & out_ready & ~flush;
    load_main_c = accept_c & (~out_valid_q | out_ready);
  end

  // Fold interrupt / overflow / kill into the offered beat, first match wins.
  always_comb begin
    in_beat_c = '{
      pc:          in_pc,
      en:          in_en,
      br_flag:     in_br_flag,
      exp_code:    in_exp_code,
      mem_op:      in_mem_op,
      mem_wr_data: in_mem_wr_data,
      ctrl_op:     in_ctrl_op,
      dst_addr:    in_dst_addr,
      gpr_we_:     in_gpr_we_,
      data:        alu_data
    };
    san_beat_c = in_beat_c;
    if (int_detect || int_pend_q || alu_overflow || kill_q) begin
      san_beat_c.mem_op      = '0;
      san_beat_c.mem_wr_data = '0;
      san_beat_c.ctrl_op     = '0;
      san_beat_c.dst_addr    = '0;
      san_beat_c.gpr_we_     = 1'b1;
      san_beat_c.data        = '0;
    end
    if (int_detect || int_pend_q) begin
      san_beat_c.exp_code = EXP_INT_C;
    end else if (alu_overflow) begin
      san_beat_c.exp_code = EXP_OVF_C;
    end else if (kill_q) begin
      san_beat_c.en       = 1'b0;
      san_beat_c.exp_code = EXP_NONE_C;
    end
  end

  // Next occupancy of the skid slot; in_ready is registered from it.
  always_comb begin
    skid_valid_d_c = skid_valid_q;
    if (flush) begin
      skid_valid_d_c = 1'b0;
    end else if (xfer_c && skid_valid_q) begin
      skid_valid_d_c = 1'b0;
    end else if (accept_c && !load_main_c) begin
      skid_valid_d_c = 1'b1;
    end
  end

  // Main register and valid flags.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_q       <= BEAT_RST;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      if (xfer_c && skid_valid_q) begin
        main_q      <= skid_q;
        out_valid_q <= 1'b1;
      end else if (load_main_c) begin
        main_q      <= san_beat_c;
        out_valid_q <= 1'b1;
      end else if (xfer_c) begin
        out_valid_q <= 1'b0;
      end
      skid_valid_q <= skid_valid_d_c;
      in_ready_q   <= ~skid_valid_d_c;
    end
  end

  // Skid payload; only meaningful while skid_valid_q is set.
  always_ff @(posedge clk) begin
    if (accept_c && !load_main_c) begin
      skid_q <= san_beat_c;
    end
  end

  // Pending interrupt, kill window and exceptional-beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_pend_q <= 1'b0;
      kill_q     <= 1'b0;
      exc_cnt_q  <= '0;
    end else begin
      if (accept_c) begin
        int_pend_q <= 1'b0;
      end else if (int_detect) begin
        int_pend_q <= 1'b1;
      end
      if (flush) begin
        kill_q <= 1'b0;
      end else if (accept_c && (san_beat_c.exp_code != EXP_NONE_C)) begin
        kill_q <= 1'b1;
      end
      if (xfer_c && (main_q.exp_code != EXP_NONE_C) && (exc_cnt_q != '1)) begin
        exc_cnt_q <= exc_cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_pc          = main_q.pc;
  assign out_en          = main_q.en;
  assign out_br_flag     = main_q.br_flag;
  assign out_exp_code    = main_q.exp_code;
  assign out_mem_op      = main_q.mem_op;
  assign out_mem_wr_data = main_q.mem_wr_data;
  assign out_ctrl_op     = main_q.ctrl_op;
  assign out_dst_addr    = main_q.dst_addr;
  assign out_gpr_we_     = main_q.gpr_we_;
  assign out_data        = main_q.data;
  assign exc_cnt         = exc_cnt_q;

endmodule

// File: tb/tb_ex_pipe_reg.sv
// Testbench for ex_pipe_reg: directed scenarios plus random traffic checked
// against a queue-based reference model of the pipeline register.
module tb_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush, int_detect, in_valid, in_ready;
  logic [29:0] in_pc;
  logic        in_en, in_br_flag;
  logic [2:0]  in_exp_code;
  logic [1:0]  in_mem_op, in_ctrl_op;
  logic [31:0] in_mem_wr_data, alu_data;
  logic [4:0]  in_dst_addr;
  logic        in_gpr_we_, alu_overflow;
  logic        out_valid, out_ready;
  logic [29:0] out_pc;
  logic        out_en, out_br_flag;
  logic [2:0]  out_exp_code;
  logic [1:0]  out_mem_op, out_ctrl_op;
  logic [31:0] out_mem_wr_data, out_data;
  logic [4:0]  out_dst_addr;
  logic        out_gpr_we_;
  logic [7:0]  exc_cnt;

  always #5 clk = ~clk;

  ex_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .int_detect(int_detect),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_en(in_en),
    .in_br_flag(in_br_flag), .in_exp_code(in_exp_code), .in_mem_op(in_mem_op),
    .in_mem_wr_data(in_mem_wr_data), .in_ctrl_op(in_ctrl_op),
    .in_dst_addr(in_dst_addr), .in_gpr_we_(in_gpr_we_), .alu_data(alu_data),
    .alu_overflow(alu_overflow), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_en(out_en), .out_br_flag(out_br_flag),
    .out_exp_code(out_exp_code), .out_mem_op(out_mem_op),
    .out_mem_wr_data(out_mem_wr_data), .out_ctrl_op(out_ctrl_op),
    .out_dst_addr(out_dst_addr), .out_gpr_we_(out_gpr_we_),
    .out_data(out_data), .exc_cnt(exc_cnt)
  );

  typedef struct packed {
    logic [29:0] pc;
    logic        en;
    logic        br_flag;
    logic [2:0]  exp_code;
    logic [1:0]  mem_op;
    logic [31:0] mem_wr_data;
    logic [1:0]  ctrl_op;
    logic [4:0]  dst_addr;
    logic        gpr_we_;
    logic [31:0] data;
  } beat_t;

  beat_t q[$];
  bit    m_pend, m_kill;
  int    m_cnt;
  int    checks = 0;
  int    errors = 0;

  // Expected beat for the currently offered inputs under the model state.
  function automatic beat_t model_beat();
    beat_t b;
    bit    san, bubble;
    b = '{pc: in_pc, en: in_en, br_flag: in_br_flag, exp_code: in_exp_code,
          mem_op: in_mem_op, mem_wr_data: in_mem_wr_data, ctrl_op: in_ctrl_op,
          dst_addr: in_dst_addr, gpr_we_: in_gpr_we_, data: alu_data};
    san = 1'b0;
    bubble = 1'b0;
    if (int_detect || m_pend) begin san = 1'b1; b.exp_code = 3'd1; end
    else if (alu_overflow) begin san = 1'b1; b.exp_code = 3'd4; end
    else if (m_kill) begin bubble = 1'b1; end
    if (san || bubble) begin
      b.mem_op = 0; b.mem_wr_data = 0; b.ctrl_op = 0;
      b.dst_addr = 0; b.gpr_we_ = 1'b1; b.data = 0;
    end
    if (bubble) begin b.en = 1'b0; b.exp_code = 3'd0; end
    return b;
  endfunction

  // Check DUT against model, advance model, clock one cycle.
  task automatic step();
    beat_t got, nb;
    bit    acc, xfer;
    checks++;
    if (out_valid !== (q.size() > 0)) begin
      errors++; $display("FAIL out_valid got %b exp %b", out_valid, q.size() > 0);
    end
    checks++;
    if (in_ready !== (q.size() < 2)) begin
      errors++; $display("FAIL in_ready got %b exp %b", in_ready, q.size() < 2);
    end
    checks++;
    if (exc_cnt !== 8'(m_cnt)) begin
      errors++; $display("FAIL exc_cnt got %0d exp %0d", exc_cnt, m_cnt);
    end
    if (q.size() > 0) begin
      got = {out_pc, out_en, out_br_flag, out_exp_code, out_mem_op, out_mem_wr_data,
             out_ctrl_op, out_dst_addr, out_gpr_we_, out_data};
      checks++;
      if (got !== q[0]) begin
        errors++; $display("FAIL out_beat got %h exp %h", got, q[0]);
      end
    end
    if (rst) begin
      q.delete(); m_pend = 0; m_kill = 0; m_cnt = 0;
    end else begin
      acc  = in_valid && (q.size() < 2) && !flush;
      xfer = (q.size() > 0) && out_ready && !flush;
      nb   = model_beat();
      if (flush) begin q.delete(); m_kill = 0; end
      if (xfer) begin
        if (q[0].exp_code != 0 && m_cnt < 255) m_cnt++;
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back(nb); m_pend = 0;
        if (nb.exp_code != 0) m_kill = 1;
      end else if (int_detect) begin
        m_pend = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; int_detect = 0; flush = 0; alu_overflow = 0; rst = 0;
  endtask

  task automatic set_beat(input logic [29:0] pc, input logic [31:0] data);
    in_valid = 1; in_pc = pc; alu_data = data; in_en = 1'b1;
    in_br_flag = 1'($urandom); in_exp_code = 0; in_mem_op = 2'($urandom);
    in_mem_wr_data = $urandom; in_ctrl_op = 2'($urandom);
    in_dst_addr = 5'($urandom); in_gpr_we_ = 1'($urandom); alu_overflow = 0;
  endtask

  task automatic do_flush();
    idle(); out_ready = 0; flush = 1; step(); flush = 0;
  endtask

  task automatic drain();
    idle(); out_ready = 1;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_reset();
    idle(); set_beat(30'd0, 32'd0); in_valid = 0; out_ready = 0; rst = 1;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    rst = 0; q.delete(); m_pend = 0; m_kill = 0; m_cnt = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || exc_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_ctrl got v=%b r=%b c=%0d", out_valid, in_ready, exc_cnt);
    end
    checks++;
    if (out_gpr_we_ !== 1'b1 || out_exp_code !== 3'd0 || out_pc !== 30'd0 ||
        out_data !== 32'd0 || out_dst_addr !== 5'd0 || out_en !== 1'b0) begin
      errors++; $display("FAIL reset_fields got we=%b exp=%0d pc=%h data=%h",
                         out_gpr_we_, out_exp_code, out_pc, out_data);
    end
  endtask

  task automatic test_streaming();
    idle(); out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      set_beat(30'(i), 32'(i * 32'h11));
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i * 32'h11) || in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_%0d got v=%b d=%h r=%b exp d=%h", i, out_valid,
                           out_data, in_ready, 32'(i * 32'h11));
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    idle(); out_ready = 1;
    set_beat(30'h20, 32'hA0); step();
    out_ready = 0;
    set_beat(30'h21, 32'hA1); step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA0) begin
      errors++; $display("FAIL bp_stall got r=%b v=%b d=%h exp r=0 v=1 d=a0",
                         in_ready, out_valid, out_data);
    end
    set_beat(30'h22, 32'hA2); step();
    set_beat(30'h23, 32'hA3); step();
    idle(); out_ready = 1;
    step();
    checks++;
    if (out_data !== 32'hA1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_order got d=%h v=%b exp d=a1", out_data, out_valid);
    end
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_drain got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_overflow();
    do_flush();
    out_ready = 1;
    set_beat(30'h100, 32'h1234); alu_overflow = 1; in_dst_addr = 5'd7; in_gpr_we_ = 0;
    step();
    checks++;
    if (out_exp_code !== 3'd4 || out_gpr_we_ !== 1'b1 || out_dst_addr !== 5'd0 ||
        out_pc !== 30'h100 || out_data !== 32'd0) begin
      errors++; $display("FAIL ovf_beat got exp=%0d we=%b dst=%0d pc=%h d=%h",
                         out_exp_code, out_gpr_we_, out_dst_addr, out_pc, out_data);
    end
    for (int i = 0; i < 2; i++) begin
      set_beat(30'(30'h104 + i), 32'h55); in_exp_code = 3'd2;
      step();
      checks++;
      if (out_en !== 1'b0 || out_exp_code !== 3'd0 || out_data !== 32'd0) begin
        errors++; $display("FAIL ovf_bubble_%0d got en=%b exp=%0d d=%h", i, out_en,
                           out_exp_code, out_data);
      end
    end
    drain();
    do_flush();
    out_ready = 1;
    set_beat(30'h200, 32'hCAFE); in_dst_addr = 5'd9; in_gpr_we_ = 0;
    step();
    checks++;
    if (out_data !== 32'hCAFE || out_en !== 1'b1 || out_dst_addr !== 5'd9 ||
        out_gpr_we_ !== 1'b0 || out_exp_code !== 3'd0) begin
      errors++; $display("FAIL ovf_after_flush got d=%h en=%b dst=%0d we=%b exp=%0d",
                         out_data, out_en, out_dst_addr, out_gpr_we_, out_exp_code);
    end
    drain();
  endtask

  task automatic test_int_pend();
    do_flush();
    idle(); out_ready = 1; int_detect = 1; step();
    do_flush();
    out_ready = 1;
    set_beat(30'h300, 32'h77); step();
    checks++;
    if (out_exp_code !== 3'd1 || out_data !== 32'd0) begin
      errors++; $display("FAIL int_pend got exp=%0d d=%h exp 1", out_exp_code, out_data);
    end
    drain();
  endtask

  task automatic test_int_vs_ovf();
    do_flush();
    out_ready = 1;
    set_beat(30'h400, 32'h88); int_detect = 1; alu_overflow = 1; step();
    checks++;
    if (out_exp_code !== 3'd1) begin
      errors++; $display("FAIL int_vs_ovf got %0d exp 1", out_exp_code);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      set_beat(30'($urandom), $urandom);
      in_valid     = ($urandom_range(0, 3) != 0);
      in_en        = 1'($urandom);
      in_exp_code  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd0;
      alu_overflow = ($urandom_range(0, 11) == 0);
      int_detect   = ($urandom_range(0, 15) == 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      if (flush) out_ready = 0;
      step();
    end
    drain();
  endtask

  task automatic test_counter_reset();
    do_flush();
    out_ready = 1;
    for (int i = 0; i < 300; i++) begin
      set_beat(30'(i), 32'(i)); alu_overflow = 1; step();
    end
    drain();
    checks++;
    if (exc_cnt !== 8'd255) begin
      errors++; $display("FAIL cnt_sat got %0d exp 255", exc_cnt);
    end
    out_ready = 0;
    set_beat(30'h500, 32'h1); step();
    set_beat(30'h501, 32'h2); step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL skid_full got r=%b v=%b exp r=0 v=1", in_ready, out_valid);
    end
    rst = 1; out_ready = 1; step(); rst = 0; idle();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || exc_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_mid got v=%b r=%b c=%0d exp 0 1 0", out_valid,
                         in_ready, exc_cnt);
    end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_overflow();
    test_int_pend();
    test_int_vs_ovf();
    test_random();
    test_counter_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
